trng_ctrl: RTL and testbench
============================

# trng_ctrl

Sequencing and sharing controller for the ring-oscillator TRNG entropy path.
- Powers the oscillator/collector chain up and down and enforces a warm-up interval.
- Screens each 32-bit collected word with an online health test and buffers one good word.
- Shares that word between two requesters (PicoRV32 read port, UART streamer) with round-robin arbitration.

## Interface
- `WARMUP_CYCLES`, 1024: clock cycles `src_en` is held high before words are accepted; legal range ≥1.
- `FAIL_LIMIT`, 3: consecutive health failures that force FAULT; legal range 1..255.
- `clk` in 1: sole clock.
- `rst` in 1: reset, asynchronous, active-low.
- `enable` in 1: master enable, level.
- `src_en` out 1: enables oscillators and releases the collector.
- `src_data` in 32: collected word.
- `src_valid` in 1: one-cycle strobe qualifying `src_data`.
- `req` in 2: requester request levels; bit0 = CPU, bit1 = UART.
- `gnt` out 2: one-hot grant, one-cycle pulse.
- `rdata` out 32: delivered word, valid only while `gnt` ≠ 0.
- `state` out 3: encoding OFF=0, WARMUP=1, FILL=2, READY=3, FAULT=4.
- `health_fail` out 1: sticky fault flag.
- `fail_cnt` out 8: current count of consecutive health failures.

## Operation
- **OFF**
  - `src_en`=0, buffer empty, previous-word register invalid.
  - `enable`=1 → WARMUP; warm-up counter loaded with `WARMUP_CYCLES`.
- **WARMUP**
  - `src_en`=1; the counter decrements every cycle.
  - All `src_valid` words are discarded and not health-tested.
  - Stays exactly `WARMUP_CYCLES` cycles, then → FILL.
- **FILL**
  - `src_en`=1. Each `src_valid` word is health-tested.
  - Pass: word stored in buffer, `fail_cnt` cleared → READY.
  - Fail: word discarded, `fail_cnt`+1.
  - `fail_cnt` reaching `FAIL_LIMIT` → FAULT.
- **READY**
  - Buffer full, `src_en`=1. Incoming words are still health-tested; on pass they are dropped, not stored.
  - If any `req` bit is high, the controller issues a grant in the next cycle:
    - `gnt` one-hot and `rdata` = buffer for one cycle; the buffer empties → FILL.
    - Exception: a passing `src_valid` word in the grant cycle refills the buffer directly, and the state stays READY.
- **FAULT**
  - `src_en`=0, `gnt` never asserted, `health_fail`=1.
  - Exit only via `enable`=0 → OFF, which clears `fail_cnt` and `health_fail`.
- **Arbitration**
  - A single requester wins outright.
  - When both request, the winner is the requester not granted most recently. The pointer resets to favour bit0 and updates only on a grant.
- **Health test**
  - Fails if the word equals the previous tested word, or is 0x00000000, or is 0xFFFFFFFF.
  - The first tested word after WARMUP has no predecessor; only the all-0/all-1 checks apply to it.
  - The previous-word register updates on every tested word, pass or fail.
- **Boundary conditions**
  - `enable`=0 in any state → OFF next cycle. The buffer is invalidated, and no grant is issued in that cycle even if one was pending.
  - Reset asserted mid-operation → OFF immediately, with all outputs at reset values.
  - `fail_cnt` saturates at `FAIL_LIMIT`.

## Timing
- Reset values: `src_en`=0, `gnt`=0, `rdata`=0, `state`=0, `health_fail`=0, `fail_cnt`=0.
- All outputs are registered.
- `enable` sampled high at cycle N:
  - `state`=WARMUP and `src_en`=1 from N+1.
  - FILL from N+1+`WARMUP_CYCLES`.
- Health result and buffer write occur in the cycle after the `src_valid` edge. READY is visible the following cycle.
- `req` seen at edge N while READY → `gnt`/`rdata` at N+1.
- `gnt` is a single-cycle pulse; requesters drop `req` after `gnt`. A held `req` receives the next word once READY is reached again.
- Back-to-back grants therefore need at least one passing source word between them.

## Configuration
- `TRNG_HEALTH_EN` defined:
  - Health test active as described; FAULT reachable.
- Not defined:
  - Every word passes and `fail_cnt` stays 0.
  - `health_fail` is tied to 0 and FAULT is unreachable.
  - The previous-word register and comparators are not built.

## Test plan
- **Reset/warm-up:** `rst` low → all outputs 0; `enable`=1 with `WARMUP_CYCLES`=8 → `src_en`=1, `state`=1 for exactly 8 cycles, and words strobed during WARMUP are never granted.
- **Single delivery:** in FILL, word 0x1234ABCD → READY; `req`=01 → `gnt`=01 for one cycle, `rdata`=0x1234ABCD, `state`=2.
- **Round-robin:** both `req` bits held with distinct words supplied → grants alternate 01, 10, 01, 10.
- **Health (`TRNG_HEALTH_EN`, `FAIL_LIMIT`=3):**
  - Words 0xDEADBEEF, 0xDEADBEEF, 0xFFFFFFFF, 0x00000000 → first word buffered; then `fail_cnt` 1, 2, 3 → FAULT, `health_fail`=1, `src_en`=0, requests ignored.
  - `enable`=0 → OFF with `fail_cnt`=0.
  - Without the macro, the same sequence yields no FAULT.
- **Grant plus refill:** in READY, `req`=10 coincides with passing `src_valid` 0x0F0F1234 → `gnt`=10 with the old word; buffer now holds 0x0F0F1234; `state` stays 3.
- **Abort:** `enable` dropped in the cycle a grant would issue → no `gnt`, `state`=0 next cycle, buffer empty on re-enable.

Source files
------------

// File: rtl/trng_ctrl_if.sv
// rtl/trng_ctrl_if.sv - collector and requester signals shared with trng_ctrl
//
// Purpose: bundles the entropy-collector handshake and the two-requester
// grant bus so the controller and its neighbours connect through one port.
//
// Signals:
//   src_en     controller -> collector, oscillator/collector enable
//   src_data   collector -> controller, 32-bit collected word
//   src_valid  collector -> controller, one-cycle strobe for src_data
//   req        requesters -> controller, request levels (bit0 CPU, bit1 UART)
//   gnt        controller -> requesters, one-hot single-cycle grant
//   rdata      controller -> requesters, delivered word while gnt != 0
//
// Modports: slave = trng_ctrl side, master = collector/requester side.
interface trng_ctrl_if;
  logic        src_en;
  logic [31:0] src_data;
  logic        src_valid;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [31:0] rdata;

  modport slave  (input src_data, src_valid, req, output src_en, gnt, rdata);
  modport master (output src_data, src_valid, req, input src_en, gnt, rdata);
endinterface

// File: rtl/trng_ctrl.sv
// rtl/trng_ctrl.sv - TRNG sequencing, health screening and two-port sharing
//
// Purpose: powers the ring-oscillator chain, waits out warm-up, screens each
// collected word with an online health test, buffers one good word and hands
// it to the CPU or UART requester under round-robin arbitration.
//
// Ports:
//   clk          sole clock
//   rst          asynchronous active-low reset
//   enable       master enable level; low forces OFF the next cycle
//   bus          trng_ctrl_if.slave (src_en/src_data/src_valid, req/gnt/rdata)
//   state        OFF=0 WARMUP=1 FILL=2 READY=3 FAULT=4
//   health_fail  sticky fault flag, cleared only by leaving via OFF
//   fail_cnt     consecutive health failures, saturating at FAIL_LIMIT
//
// Build option TRNG_HEALTH_EN: builds the health test (repeat, all-zero and
// all-one rejection) and the FAULT path. Without it every word passes,
// fail_cnt stays 0 and health_fail is tied low.
module trng_ctrl #(
  parameter int unsigned WARMUP_CYCLES = 1024,
  parameter int unsigned FAIL_LIMIT    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  trng_ctrl_if.slave  bus,
  output logic [2:0]  state,
  output logic        health_fail,
  output logic [7:0]  fail_cnt
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_WARMUP = 3'd1,
    S_FILL   = 3'd2,
    S_READY  = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  localparam int unsigned   CW        = $clog2(WARMUP_CYCLES + 1);
  localparam logic [CW-1:0] WARM_LOAD = CW'(WARMUP_CYCLES);
  localparam logic [7:0]    LIMIT     = 8'(FAIL_LIMIT);

  state_t        state_q, state_d;
  logic [CW-1:0] warm_q, warm_d;
  logic [31:0]   buf_q, buf_d;
  logic [7:0]    fail_q, fail_d;
  logic          last_uart_q, last_uart_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          src_en_q;
  logic          tested;
  logic          pass;

  // Only words arriving while the buffer path is live are screened; warm-up
  // words and anything in a cycle where enable drops are ignored outright.
  assign tested = enable && bus.src_valid && (state_q == S_FILL || state_q == S_READY);

`ifdef TRNG_HEALTH_EN
  logic [31:0] prev_q;
  logic        prev_vld_q;
  logic        hf_q;

  assign pass = (bus.src_data != 32'h0000_0000) &&
                (bus.src_data != 32'hFFFF_FFFF) &&
                !(prev_vld_q && bus.src_data == prev_q);

  // The previous word is forgotten in OFF so the first word after warm-up
  // is only checked against the stuck-at patterns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q     <= 32'h0;
      prev_vld_q <= 1'b0;
      hf_q       <= 1'b0;
    end else begin
      if (state_q == S_OFF) begin
        prev_vld_q <= 1'b0;
      end else if (tested) begin
        prev_q     <= bus.src_data;
        prev_vld_q <= 1'b1;
      end
      hf_q <= (state_d == S_FAULT);
    end
  end

  assign health_fail = hf_q;
`else
  assign pass        = 1'b1;
  assign health_fail = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    warm_d      = warm_q;
    buf_d       = buf_q;
    fail_d      = fail_q;
    last_uart_d = last_uart_q;
    gnt_d       = 2'b00;
    rdata_d     = 32'h0;
    if (!enable) begin
      state_d = S_OFF;
      fail_d  = 8'h00;
    end else begin
      if (tested) begin
        if (pass)
          fail_d = 8'h00;
        else if (fail_q < LIMIT)
          fail_d = fail_q + 8'h01;
      end
      case (state_q)
        S_OFF: begin
          state_d = S_WARMUP;
          warm_d  = WARM_LOAD;
        end
        S_WARMUP: begin
          warm_d = warm_q - CW'(1);
          if (warm_q <= CW'(1))
            state_d = S_FILL;
        end
        S_FILL: begin
          if (tested && pass) begin
            buf_d   = bus.src_data;
            state_d = S_READY;
          end
        end
        S_READY: begin
          if (bus.req != 2'b00) begin
            // With both requesting, the one not served last time wins.
            if (bus.req == 2'b11)
              gnt_d = last_uart_q ? 2'b01 : 2'b10;
            else
              gnt_d = bus.req;
            rdata_d     = buf_q;
            last_uart_d = gnt_d[1];
            // A good word landing in the grant cycle refills the buffer
            // directly instead of dropping back to FILL.
            if (tested && pass)
              buf_d = bus.src_data;
            else
              state_d = S_FILL;
          end
        end
        S_FAULT: ;
        default: state_d = S_OFF;
      endcase
      // Reaching the failure limit wins over any grant decided above.
      if (tested && !pass && fail_d == LIMIT) begin
        state_d     = S_FAULT;
        gnt_d       = 2'b00;
        rdata_d     = 32'h0;
        last_uart_d = last_uart_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_OFF;
      warm_q      <= '0;
      buf_q       <= 32'h0;
      fail_q      <= 8'h00;
      last_uart_q <= 1'b1;
      gnt_q       <= 2'b00;
      rdata_q     <= 32'h0;
      src_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      warm_q      <= warm_d;
      buf_q       <= buf_d;
      fail_q      <= fail_d;
      last_uart_q <= last_uart_d;
      gnt_q       <= gnt_d;
      rdata_q     <= rdata_d;
      src_en_q    <= (state_d == S_WARMUP) || (state_d == S_FILL) || (state_d == S_READY);
    end
  end

  assign bus.src_en = src_en_q;
  assign bus.gnt    = gnt_q;
  assign bus.rdata  = rdata_q;
  assign state      = state_q;
  assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_trng_ctrl.sv
// tb/tb_trng_ctrl.sv - scoreboard bench for trng_ctrl
module tb_trng_ctrl;
  localparam int W     = 8;
  localparam int LIMIT = 3;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] state;
  logic       health_fail;
  logic [7:0] fail_cnt;

  trng_ctrl_if bus();

  trng_ctrl #(.WARMUP_CYCLES(W), .FAIL_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus),
    .state(state), .health_fail(health_fail), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: mode uses the published state numbering; grants are
  // queued with the monitor cycle at which they must appear.
  typedef struct { logic [1:0] g; logic [31:0] w; int c; } grant_t;
  grant_t      exp_q[$];
  grant_t      mon_e;
  int          cyc       = 0;
  int          m_mode    = 0;
  int          m_warm    = 0;
  int          m_fails   = 0;
  int          m_last    = 1;
  logic [31:0] m_word    = 32'h0;
  logic [31:0] m_prev    = 32'h0;
  bit          m_prev_ok = 1'b0;

  function automatic bit healthy(input logic [31:0] d);
`ifdef TRNG_HEALTH_EN
    return (d != 32'h0) && (d != 32'hFFFF_FFFF) && !(m_prev_ok && d == m_prev);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_warm = 0; m_fails = 0; m_last = 1; m_prev_ok = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit en, input bit v, input logic [31:0] d, input logic [1:0] r);
    int mode0;
    bit tested, ok, fault;
    int win;
    grant_t e;
    mode0 = m_mode;
    if (!en) begin
      m_mode = 0; m_fails = 0; m_prev_ok = 1'b0;
      return;
    end
    tested = v && (mode0 == 2 || mode0 == 3);
    ok     = healthy(d);
    fault  = 1'b0;
    if (tested) begin
      m_prev = d; m_prev_ok = 1'b1;
      if (ok) m_fails = 0;
      else if (m_fails < LIMIT) m_fails++;
      fault = !ok && (m_fails == LIMIT);
    end
    case (mode0)
      0: begin m_mode = 1; m_warm = W; end
      1: begin m_warm--; if (m_warm == 0) m_mode = 2; end
      2: if (tested && ok) begin m_word = d; m_mode = 3; end
      3: if (r != 2'b00 && !fault) begin
           win = (r == 2'b11) ? 1 - m_last : ((r == 2'b01) ? 0 : 1);
           e.g = 2'(1 << win); e.w = m_word; e.c = cyc + 1;
           exp_q.push_back(e);
           m_last = win;
           if (tested && ok) m_word = d;
           else m_mode = 2;
         end
      default: ;
    endcase
    if (fault) m_mode = 4;
  endtask

  // Monitor: status every cycle, grants popped from the scoreboard.
  always @(posedge clk) begin
    #1;
    cyc++;
    check("status", {51'b0, state, bus.src_en, health_fail, fail_cnt},
          {51'b0, 3'(m_mode), (m_mode inside {1, 2, 3}), (m_mode == 4), 8'(m_fails)});
    if (bus.gnt !== 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_gnt", {30'b0, bus.gnt, bus.rdata}, 64'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("gnt", 64'(bus.gnt), 64'(mon_e.g));
        check("rdata", 64'(bus.rdata), 64'(mon_e.w));
        check("gnt_cycle", 64'(cyc), 64'(mon_e.c));
      end
    end
    while (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
      check("missing_gnt", 64'(bus.gnt), 64'(exp_q[0].g));
      void'(exp_q.pop_front());
    end
  end

  task automatic cycle(input bit en, input bit v, input logic [31:0] d, input logic [1:0] r);
    @(negedge clk);
    enable = en; bus.src_valid = v; bus.src_data = d; bus.req = r;
    model_step(en, v, d, r);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0; enable = 1'b0; bus.src_valid = 1'b0; bus.src_data = 32'h0; bus.req = 2'b00;
    model_reset();
    #1;
    check("async_reset", {17'b0, bus.gnt, bus.rdata, state, bus.src_en, health_fail, fail_cnt}, 64'h0);
    repeat (n) @(negedge clk);
    rst = 1'b1;
  endtask

  // Enable edge plus W warm-up cycles, strobing random words throughout.
  task automatic warm_up(input logic [1:0] r);
    for (int i = 0; i <= W; i++) cycle(1'b1, 1'b1, 32'($urandom), r);
  endtask

  function automatic logic [31:0] good_word();
    logic [31:0] w;
    do w = 32'($urandom); while (w == 32'h0 || w == 32'hFFFF_FFFF || w == m_prev);
    return w;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.src_valid = 1'b0; bus.src_data = 32'h0; bus.req = 2'b00;
    model_reset();
    do_reset(3);

    // Warm-up with requests held: nothing may be granted.
    warm_up(2'b01);

    // Single delivery.
    cycle(1'b1, 1'b1, 32'h1234ABCD, 2'b00);
    cycle(1'b1, 1'b0, 32'h0, 2'b01);
    cycle(1'b1, 1'b0, 32'h0, 2'b00);

    // Round robin with both requests held.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, good_word(), 2'b11);
      cycle(1'b1, 1'b0, 32'h0, 2'b11);
    end
    cycle(1'b1, 1'b0, 32'h0, 2'b00);

    // Health sequence from a fresh start.
    cycle(1'b0, 1'b0, 32'h0, 2'b00);
    warm_up(2'b00);
    cycle(1'b1, 1'b1, 32'hDEADBEEF, 2'b00);
    cycle(1'b1, 1'b1, 32'hDEADBEEF, 2'b00);
    cycle(1'b1, 1'b1, 32'hFFFFFFFF, 2'b00);
    cycle(1'b1, 1'b1, 32'h00000000, 2'b00);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 2'b11);
    settle();
`ifdef TRNG_HEALTH_EN
    check("fault_reached", 64'({state, health_fail, bus.src_en, fail_cnt}),
          64'({3'd4, 1'b1, 1'b0, 8'd3}));
`else
    check("no_fault", 64'({state, health_fail, fail_cnt}), 64'({3'd2, 1'b0, 8'd0}));
`endif
    cycle(1'b0, 1'b0, 32'h0, 2'b00);
    settle();
    check("disable_clears", 64'({state, health_fail, fail_cnt}), 64'h0);

    // Grant coinciding with a passing refill word.
    warm_up(2'b00);
    cycle(1'b1, 1'b1, good_word(), 2'b00);
    cycle(1'b1, 1'b1, 32'h0F0F1234, 2'b10);
    settle();
    check("refill_ready", 64'(state), 64'd3);
    cycle(1'b1, 1'b0, 32'h0, 2'b01);
    cycle(1'b1, 1'b0, 32'h0, 2'b00);

    // Abort: enable drops in the cycle a grant would issue.
    cycle(1'b1, 1'b1, good_word(), 2'b00);
    cycle(1'b0, 1'b0, 32'h0, 2'b01);
    settle();
    check("abort_off", 64'({state, bus.gnt}), 64'h0);
    warm_up(2'b00);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 2'b01);
    settle();
    check("reenable_empty", 64'({state, bus.gnt}), 64'({3'd2, 2'b00}));

    // Reset in the middle of operation.
    cycle(1'b1, 1'b1, good_word(), 2'b00);
    do_reset(2);

    // Randomised traffic including bad words and occasional disables.
    for (int i = 0; i < 800; i++) begin
      bit          en, v;
      logic [31:0] d;
      logic [1:0]  r;
      int          k;
      en = ($urandom_range(0, 59) != 0);
      v  = ($urandom_range(0, 2) == 0);
      k  = $urandom_range(0, 9);
      d  = (k == 0) ? 32'h0 : (k == 1) ? 32'hFFFF_FFFF : (k == 2) ? m_prev : 32'($urandom);
      r  = 2'($urandom_range(0, 3));
      cycle(en, v, d, r);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 2'b00);
    settle();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
